// File: rtl/puf_sample_seq.sv
// puf_sample_seq
//
// Sequencer that drives one PUF key generation through the majority voter.
// On an accepted start it clears the voter, collects NUM_SAMPLES raw
// readouts from the PUF (one req/ack handshake each), and pushes every
// readout into the voter with a one-cycle accumulate strobe. It then
// commands the vote, captures the voted word, and clears the voter again.
// Finally it offers the word to the key consumer under a valid/ack
// handshake. If the PUF or the voter stays silent for TIMEOUT cycles, the
// run is aborted and a sticky error flag is raised.
//
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   start        begin one generation (only looked at while idle)
//   busy         high whenever the sequencer is not idle
//   puf_req      level request for one PUF readout
//   puf_ack      one-cycle pulse, puf_data valid
//   puf_data     raw PUF response word
//   vote_ready   voter accumulate strobe, vote_data valid
//   vote_data    word handed to the voter
//   vote_go      voter evaluate request, held until vote_done
//   vote_clear   voter clear strobe
//   vote_done    voter result valid
//   vote_result  voted word from the voter
//   key_valid    key_out valid, held until key_ack
//   key_out      voted key word, held until the next capture
//   key_ack      consumer accepts key_out
//   err_timeout  sticky abort flag, cleared by the next accepted start
//   sample_cnt   number of samples pushed in the current run

module puf_sample_seq #(
    parameter int WIDTH       = 128,
    parameter int NUM_SAMPLES = 9,
    parameter int TIMEOUT     = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             puf_req,
    input  logic             puf_ack,
    input  logic [WIDTH-1:0] puf_data,
    output logic             vote_ready,
    output logic [WIDTH-1:0] vote_data,
    output logic             vote_go,
    output logic             vote_clear,
    input  logic             vote_done,
    input  logic [WIDTH-1:0] vote_result,
    output logic             key_valid,
    output logic [WIDTH-1:0] key_out,
    input  logic             key_ack,
    output logic             err_timeout,
    output logic [5:0]       sample_cnt
);

    localparam logic [5:0] SAMPLES_LAST = 6'(NUM_SAMPLES);
    localparam logic [9:0] TMO_LAST     = 10'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLR0,
        S_REQ,
        S_PUSH,
        S_VOTE,
        S_CAP,
        S_CLR1,
        S_OUT,
        S_ABORT
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [9:0] tmo_cnt;
    logic       tmo_hit;

    // The wait counter holds the number of completed cycles in the current
    // REQ/VOTE visit minus one. Comparing against TIMEOUT-1 therefore leaves
    // after exactly TIMEOUT cycles in the waiting state.
    assign tmo_hit = (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A handshake response wins over a timeout that expires in the same cycle.
    // sample_cnt already counts the sample being pushed while in PUSH.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_CLR0;
            S_CLR0:  state_next = S_REQ;
            S_REQ: begin
                if (puf_ack) begin
                    state_next = S_PUSH;
                end else if (tmo_hit) begin
                    state_next = S_ABORT;
                end
            end
            S_PUSH:  state_next = (sample_cnt == SAMPLES_LAST) ? S_VOTE : S_REQ;
            S_VOTE: begin
                if (vote_done) begin
                    state_next = S_CAP;
                end else if (tmo_hit) begin
                    state_next = S_ABORT;
                end
            end
            S_CAP:   state_next = S_CLR1;
            S_CLR1:  state_next = S_OUT;
            S_OUT:   if (key_ack) state_next = S_IDLE;
            S_ABORT: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Restarts on every state change so each REQ and VOTE visit gets a fresh
    // budget, including back-to-back REQ visits separated by a PUSH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state_next != state) begin
            tmo_cnt <= '0;
        end else if (state == S_REQ || state == S_VOTE) begin
            tmo_cnt <= tmo_cnt + 10'd1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    // All handshake outputs are registered from the next state, so each one
    // is high exactly while its state is occupied. The voter strobes belong
    // to distinct states and are therefore one cycle wide and exclusive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy        <= 1'b0;
            puf_req     <= 1'b0;
            vote_ready  <= 1'b0;
            vote_go     <= 1'b0;
            vote_clear  <= 1'b0;
            key_valid   <= 1'b0;
            err_timeout <= 1'b0;
            sample_cnt  <= '0;
            vote_data   <= '0;
            key_out     <= '0;
        end else begin
            busy       <= (state_next != S_IDLE);
            puf_req    <= (state_next == S_REQ);
            vote_ready <= (state_next == S_PUSH);
            vote_go    <= (state_next == S_VOTE);
            vote_clear <= (state_next == S_CLR0) || (state_next == S_CLR1) ||
                          (state_next == S_ABORT);
            key_valid  <= (state_next == S_OUT);

            if (state == S_IDLE && start) begin
                err_timeout <= 1'b0;
                sample_cnt  <= '0;
            end else if (state_next == S_ABORT) begin
                err_timeout <= 1'b1;
            end

            if (state == S_REQ && puf_ack) begin
                vote_data  <= puf_data;
                sample_cnt <= sample_cnt + 6'd1;
            end

            if (state == S_CAP) begin
                key_out <= vote_result;
            end
        end
    end

endmodule

// File: tb/tb_puf_sample_seq.sv
// tb_puf_sample_seq
//
// Directed run sequence for puf_sample_seq with randomized PUF words.
// A negedge PUF responder acks one cycle after each request. A negedge
// voter model accumulates the pushed words and answers vote_go one cycle
// later. Expected keys come from a per-bit ones count over the words the
// bench handed to the PUF for that run.

module tb_puf_sample_seq;

    localparam int W   = 128;
    localparam int NS  = 9;
    localparam int TMO = 255;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         busy;
    logic         puf_req;
    logic         puf_ack = 1'b0;
    logic [W-1:0] puf_data = '0;
    logic         vote_ready;
    logic [W-1:0] vote_data;
    logic         vote_go;
    logic         vote_clear;
    logic         vote_done = 1'b0;
    logic [W-1:0] vote_result = '0;
    logic         key_valid;
    logic [W-1:0] key_out;
    logic         key_ack = 1'b0;
    logic         err_timeout;
    logic [5:0]   sample_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    bit stall     = 1'b0;
    bit spur_idle = 1'b0;
    bit spur_push = 1'b0;

    logic [W-1:0] samp_q[$];
    logic [W-1:0] run_samples [NS];

    int req_age = 0;
    int acc [W] = '{default: 0};
    int nacc    = 0;
    int go_age  = 0;

    int   n_ready   = 0;
    int   n_go_rise = 0;
    int   n_clear   = 0;
    int   mutex_err = 0;
    int   width_err = 0;
    logic prev_ready = 1'b0;
    logic prev_clear = 1'b0;
    logic prev_go    = 1'b0;

    int snap_ready;
    int snap_go;
    int snap_clear;

    always #5 clk = ~clk;

    puf_sample_seq #(
        .WIDTH       (W),
        .NUM_SAMPLES (NS),
        .TIMEOUT     (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .puf_req     (puf_req),
        .puf_ack     (puf_ack),
        .puf_data    (puf_data),
        .vote_ready  (vote_ready),
        .vote_data   (vote_data),
        .vote_go     (vote_go),
        .vote_clear  (vote_clear),
        .vote_done   (vote_done),
        .vote_result (vote_result),
        .key_valid   (key_valid),
        .key_out     (key_out),
        .key_ack     (key_ack),
        .err_timeout (err_timeout),
        .sample_cnt  (sample_cnt)
    );

    function automatic logic [W-1:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Expected key: a bit is set when more than half of the run's words have it set.
    function automatic logic [W-1:0] ref_vote();
        logic [W-1:0] r;
        int ones;
        r = '0;
        for (int b = 0; b < W; b++) begin
            ones = 0;
            for (int i = 0; i < NS; i++) begin
                ones += int'(run_samples[i][b]);
            end
            r[b] = (ones > NS / 2);
        end
        return r;
    endfunction

    // PUF: answers the second cycle a request is seen, and can inject stray acks.
    always @(negedge clk) begin
        puf_ack = 1'b0;
        if (puf_req && !stall) begin
            req_age++;
            if (req_age == 2) begin
                puf_ack = 1'b1;
                if (samp_q.size() > 0) begin
                    puf_data = samp_q.pop_front();
                end else begin
                    puf_data = rand128();
                end
            end
        end else begin
            req_age = 0;
        end
        if (spur_push && vote_ready) begin
            puf_ack  = 1'b1;
            puf_data = rand128();
        end
        if (spur_idle && !busy) begin
            puf_ack  = 1'b1;
            puf_data = rand128();
        end
    end

    // Voter: not reset by rst, so only vote_clear removes old sums.
    always @(negedge clk) begin
        if (vote_clear) begin
            for (int b = 0; b < W; b++) acc[b] = 0;
            nacc = 0;
        end else if (vote_ready) begin
            for (int b = 0; b < W; b++) acc[b] += int'(vote_data[b]);
            nacc++;
        end
        if (vote_go) begin
            go_age++;
            if (go_age >= 2) begin
                vote_done = 1'b1;
                for (int b = 0; b < W; b++) vote_result[b] = (2 * acc[b] > nacc);
            end
        end else begin
            go_age    = 0;
            vote_done = 1'b0;
        end
    end

    // Strobe bookkeeping.
    always @(negedge clk) begin
        if (vote_ready) n_ready++;
        if (vote_clear) n_clear++;
        if (vote_go && !prev_go) n_go_rise++;
        if (int'(vote_ready) + int'(vote_go) + int'(vote_clear) > 1) mutex_err++;
        if ((vote_ready && prev_ready) || (vote_clear && prev_clear)) width_err++;
        prev_ready = vote_ready;
        prev_clear = vote_clear;
        prev_go    = vote_go;
    end

    task automatic checkOutput(input string tag, input logic [W-1:0] obs,
                               input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One-cycle start pulse; returns at the negedge after it was sampled.
    task automatic applyStimulus();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_generation(output int lat);
        samp_q.delete();
        for (int i = 0; i < NS; i++) samp_q.push_back(run_samples[i]);
        snap_ready = n_ready;
        snap_go    = n_go_rise;
        snap_clear = n_clear;
        applyStimulus();
        checkOutput("clr0_first", W'(vote_clear), W'(1));
        checkOutput("err_cleared", W'(err_timeout), W'(0));
        lat = 0;
        while (!key_valid && lat < 400) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic ack_key();
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
        checkOutput("ack_valid_low", W'(key_valid), W'(0));
        checkOutput("ack_idle", W'(busy), W'(0));
    endtask

    initial begin
        int           lat;
        int           k;
        int           nreq;
        int           bad;
        int           c0;
        logic [W-1:0] held;
        logic [W-1:0] expk;

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", W'(busy), W'(0));
        checkOutput("rst_strobes", W'({puf_req, vote_ready, vote_go, vote_clear, key_valid}), W'(0));
        checkOutput("rst_key", key_out, W'(0));
        checkOutput("rst_cnt", W'(sample_cnt), W'(0));
        rst = 1'b0;
        @(negedge clk);

        // Run 1: constant 0xA5 words, latency and strobe counts.
        $display("[TB] run 1: constant words");
        for (int i = 0; i < NS; i++) run_samples[i] = {16{8'hA5}};
        run_generation(lat);
        checkOutput("latency_r1", W'(lat), W'(3 * NS + 5));
        checkOutput("key_r1", key_out, {16{8'hA5}});
        checkOutput("ready_pulses", W'(n_ready - snap_ready), W'(NS));
        checkOutput("go_windows", W'(n_go_rise - snap_go), W'(1));
        checkOutput("clear_pulses", W'(n_clear - snap_clear), W'(2));
        checkOutput("cnt_out", W'(sample_cnt), W'(NS));

        // Consumer stalls 20 cycles; a start pulse meanwhile is ignored.
        held = key_out;
        bad  = 0;
        for (int c = 0; c < 20; c++) begin
            if (c == 5) start = 1'b1;
            if (c == 6) start = 1'b0;
            @(negedge clk);
            if (!key_valid || key_out !== held) bad++;
        end
        checkOutput("hold_stable", W'(bad), W'(0));
        checkOutput("hold_busy", W'(busy), W'(1));
        ack_key();
        checkOutput("key_kept_idle", key_out, {16{8'hA5}});
        checkOutput("cnt_kept_idle", W'(sample_cnt), W'(NS));

        // Stray acks while idle.
        snap_ready = n_ready;
        spur_idle  = 1'b1;
        repeat (5) @(negedge clk);
        spur_idle = 1'b0;
        @(negedge clk);
        checkOutput("spur_idle_ready", W'(n_ready - snap_ready), W'(0));
        checkOutput("spur_idle_cnt", W'(sample_cnt), W'(NS));
        checkOutput("spur_idle_busy", W'(busy), W'(0));

        // Run 2: bit0 set in 5 words, bit1 in 4, stray acks during PUSH.
        $display("[TB] run 2: majority boundary");
        for (int i = 0; i < NS; i++) begin
            run_samples[i]    = rand128();
            run_samples[i][0] = (i < 5);
            run_samples[i][1] = (i >= 5);
        end
        expk      = ref_vote();
        spur_push = 1'b1;
        run_generation(lat);
        spur_push = 1'b0;
        checkOutput("latency_r2", W'(lat), W'(3 * NS + 5));
        checkOutput("key_bit0", W'(key_out[0]), W'(1));
        checkOutput("key_bit1", W'(key_out[1]), W'(0));
        checkOutput("key_r2", key_out, expk);
        checkOutput("spur_push_ready", W'(n_ready - snap_ready), W'(NS));
        checkOutput("spur_push_cnt", W'(sample_cnt), W'(NS));
        held = key_out;
        ack_key();

        // Run 3: PUF never answers.
        $display("[TB] run 3: PUF stall");
        stall = 1'b1;
        samp_q.delete();
        applyStimulus();
        k = 0;
        while (!puf_req && k < 10) begin
            @(negedge clk);
            k++;
        end
        c0   = n_clear;
        nreq = 0;
        k    = 0;
        while (busy && k < 600) begin
            if (puf_req) nreq++;
            @(negedge clk);
            k++;
        end
        stall = 1'b0;
        checkOutput("tmo_req_cycles", W'(nreq), W'(TMO));
        checkOutput("tmo_err", W'(err_timeout), W'(1));
        checkOutput("tmo_key_valid", W'(key_valid), W'(0));
        checkOutput("tmo_clear", W'(n_clear - c0), W'(1));
        checkOutput("tmo_busy", W'(busy), W'(0));
        checkOutput("tmo_key_kept", key_out, held);

        // Run 4: recovery after the abort.
        $display("[TB] run 4: after timeout");
        for (int i = 0; i < NS; i++) run_samples[i] = rand128();
        expk = ref_vote();
        run_generation(lat);
        checkOutput("latency_r4", W'(lat), W'(3 * NS + 5));
        checkOutput("key_r4", key_out, expk);
        ack_key();

        // Run 5: asynchronous reset during the fourth PUSH.
        $display("[TB] run 5: reset mid-run");
        for (int i = 0; i < NS; i++) run_samples[i] = rand128();
        samp_q.delete();
        for (int i = 0; i < NS; i++) samp_q.push_back(run_samples[i]);
        applyStimulus();
        k = 0;
        while (!(vote_ready && sample_cnt == 6'd4) && k < 100) begin
            @(negedge clk);
            k++;
        end
        checkOutput("push4_reached", W'(sample_cnt), W'(4));
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_strobes", W'({busy, puf_req, vote_ready, vote_go, vote_clear, key_valid, err_timeout}), W'(0));
        checkOutput("arst_cnt", W'(sample_cnt), W'(0));
        checkOutput("arst_key", key_out, W'(0));
        checkOutput("arst_data", vote_data, W'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Run 6: fresh run must carry nothing over from run 5.
        $display("[TB] run 6: after reset");
        for (int i = 0; i < NS; i++) run_samples[i] = rand128();
        expk = ref_vote();
        run_generation(lat);
        checkOutput("latency_r6", W'(lat), W'(3 * NS + 5));
        checkOutput("key_r6", key_out, expk);
        ack_key();

        checkOutput("strobe_exclusive", W'(mutex_err), W'(0));
        checkOutput("strobe_width", W'(width_err), W'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
